// File: rtl/bp_me_wormhole_stream_encode.sv
// bp_me_wormhole_stream_encode
//   Builds a wormhole packet {data, msg, src_cid, src_cord, len, cid, cord}
//   from one memory message and streams it out LSB-first, one flit per
//   link handshake.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   header_i .. dst_cid_i   message fields (sampled on v_i & ready_and_o)
//   v_i / ready_and_o       message-side valid/ready
//   flit_o / v_o            link-side flit and valid
//   ready_and_i             link-side ready
module bp_me_wormhole_stream_encode #(
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 8,
  parameter int cid_width_p  = 4,
  parameter int len_width_p  = 4,
  parameter int hdr_width_p  = 48,
  parameter int data_width_p = 512,
  parameter int size_width_p = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [hdr_width_p-1:0]  header_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic [size_width_p-1:0] size_i,
  input  logic                    has_data_i,
  input  logic [cord_width_p-1:0] src_cord_i,
  input  logic [cid_width_p-1:0]  src_cid_i,
  input  logic [cord_width_p-1:0] dst_cord_i,
  input  logic [cid_width_p-1:0]  dst_cid_i,
  input  logic                    v_i,
  output logic                    ready_and_o,
  output logic [flit_width_p-1:0] flit_o,
  output logic                    v_o,
  input  logic                    ready_and_i
);

  localparam int hdr_bits_lp  = 2*cord_width_p + 2*cid_width_p + len_width_p + hdr_width_p;
  localparam int pkt_flits_lp = (hdr_bits_lp + data_width_p + flit_width_p - 1) / flit_width_p;
  localparam int pkt_width_lp = pkt_flits_lp * flit_width_p;
  // Size codes at or above this clamp to a full data_width_p payload
  localparam int max_size_lp  = $clog2(data_width_p / 8);

  // The largest packet's flit count minus one must be encodable in len
  if (pkt_flits_lp - 1 >= (1 << len_width_p)) begin : g_len_chk
    $error("len_width_p too small for maximum packet length");
  end

  typedef enum logic {e_ready, e_send} state_e;

  state_e                   state_q;
  logic [pkt_width_lp-1:0]  packet_q, packet_d;
  logic [len_width_p-1:0]   len_q, len_d, cnt_q;
  logic [31:0]              payload_bits;
  logic [data_width_p-1:0]  data_masked;
  logic                     last_flit, accept;

  always_comb begin
    payload_bits = '0;
    if (has_data_i)
      payload_bits = (32'(size_i) >= max_size_lp) ? 32'(data_width_p) : (32'd8 << size_i);
  end

  assign len_d = len_width_p'((hdr_bits_lp + payload_bits + flit_width_p - 1) / flit_width_p - 1);

  // Shift by >= data_width_p yields all zeros, so a full payload keeps every bit
  assign data_masked = data_i & ~({data_width_p{1'b1}} << payload_bits);

  // Zero-extension fills the tail of the last flit with 0
  assign packet_d = pkt_width_lp'({data_masked, header_i, src_cid_i, src_cord_i,
                                   len_d, dst_cid_i, dst_cord_i});

  assign last_flit   = (cnt_q == len_q);
  // Accepting on the last-flit handshake keeps the link busy with no bubble
  assign ready_and_o = (state_q == e_ready) | ((state_q == e_send) & last_flit & ready_and_i);
  assign accept      = v_i & ready_and_o;
  assign v_o         = (state_q == e_send);
  assign flit_o      = v_o ? packet_q[32'(cnt_q)*flit_width_p +: flit_width_p] : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_ready;
      cnt_q    <= '0;
      len_q    <= '0;
      packet_q <= '0;
    end else begin
      case (state_q)
        e_ready: begin
          if (accept) begin
            packet_q <= packet_d;
            len_q    <= len_d;
            cnt_q    <= '0;
            state_q  <= e_send;
          end
        end
        e_send: begin
          if (ready_and_i) begin
            if (!last_flit) begin
              cnt_q <= cnt_q + 1'b1;
            end else if (accept) begin
              packet_q <= packet_d;
              len_q    <= len_d;
              cnt_q    <= '0;
            end else begin
              state_q <= e_ready;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/bp_me_wormhole_stream_encode.md
# bp_me_wormhole_stream_encode

Sequential wormhole packet encoder and flit serializer for the memory network. It accepts one memory message per handshake: header bits, up to `data_width_p` bits of payload, a size code and routing fields. It builds a `{data, msg, src_cid, src_cord, len, cid, cord}` packet, computes `len` from the payload size, and streams the packet out LSB-first, one `flit_width_p` flit per handshake. It sits between a CCE/cache memory-command source and the wormhole router link, and generalises the combinational packet encoders with a parametrised payload width, payload masking and built-in serialization.

## Interface
Parameters:
- `flit_width_p`, "inv": link flit width in bits.
- `cord_width_p`, "inv": coordinate width.
- `cid_width_p`, "inv": concentrator id width.
- `len_width_p`, "inv": packet length field width; encodes flit count minus 1.
- `hdr_width_p`, "inv": message header (msg) width.
- `data_width_p`, "inv": maximum payload bits; a multiple of 8 and a power of 2.
- `size_width_p`, 3: size code width; bytes = 1 << `size_i`.

Ports:
- `clk_i`, in, 1: clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `header_i`, in, `hdr_width_p`: message header.
- `data_i`, in, `data_width_p`: payload, LSB-aligned.
- `size_i`, in, `size_width_p`: log2 of payload bytes.
- `has_data_i`, in, 1: message carries payload (write class).
- `src_cord_i`, in, `cord_width_p`: source coordinate.
- `src_cid_i`, in, `cid_width_p`: source concentrator id.
- `dst_cord_i`, in, `cord_width_p`: destination coordinate.
- `dst_cid_i`, in, `cid_width_p`: destination concentrator id.
- `v_i`, in, 1: message valid.
- `ready_and_o`, out, 1: message accepted when `v_i & ready_and_o`.
- `flit_o`, out, `flit_width_p`: outgoing flit.
- `v_o`, out, 1: flit valid.
- `ready_and_i`, in, 1: link accepts the flit when `v_o & ready_and_i`.

## Operation
- **Header bits:** H = cord + cid + len + src_cord + src_cid + hdr widths.
- **Payload bits:**
  - P = 0 if `!has_data_i`.
  - Otherwise P = min(8 << `size_i`, `data_width_p`). Oversized codes clamp to `data_width_p`.
- **Length:** `len` = CDIV(H+P, `flit_width_p`) - 1. Elaboration fails if CDIV(H+`data_width_p`, `flit_width_p`)-1 does not fit in `len_width_p`.
- **Payload masking:** data bits at index P and above are zeroed before packing. All padding bits in the final flit are 0.
- **Packet register:** width CDIV(H+`data_width_p`, `flit_width_p`) × `flit_width_p`, captured on input handshake. The register also holds `len_r` and flit counter `cnt_r` (width `len_width_p`).
- **FSM states:**
  - `e_ready`: `ready_and_o`=1, `v_o`=0. Input handshake → capture, `cnt_r`=0, go to `e_send`.
  - `e_send`: `v_o`=1, `flit_o` = packet_r[`cnt_r`*`flit_width_p` +: `flit_width_p`].
    - On link handshake with `cnt_r` != `len_r`: `cnt_r`++.
    - On link handshake with `cnt_r` == `len_r` (last flit): go to `e_ready`, unless a new message is accepted that cycle.
- **Back-to-back:** in `e_send`, `ready_and_o` = (`cnt_r`==`len_r`) & `ready_and_i`. A new message accepted on the last-flit handshake is captured immediately, and the block stays in `e_send` with `cnt_r`=0. This is a combinational path from `ready_and_i` to `ready_and_o`.
- **Stability:** `flit_o` is stable while `v_o` is high and `ready_and_i` is low. Inputs are ignored outside the handshake.

## Timing
- **Reset:** state = `e_ready`, `cnt_r`=0, `len_r`=0, packet_r=0. `v_o`=0, `flit_o`=0, `ready_and_o`=1 in the cycle after `reset_i` is asserted and while it is held.
- **Reset mid-packet:** the packet is dropped, with no further flits. `v_o`=0 in the cycle after reset is sampled.
- **Latency:** message accepted at cycle t → flit 0 valid at t+1.
- **Throughput:** with `ready_and_i` held high, a packet occupies `len`+1 consecutive cycles. Back-to-back packets have no bubble.
- **Backpressure:** `ready_and_i` low holds `cnt_r` and `flit_o`.

## Test plan
Configuration: flit 64, cord 8, cid 4, len 4, hdr 48, data 512, so H=76.
- **Read:** `has_data_i`=0 read, `ready_and_i`=1 → 2 flits, `len`=1. Flit 0 bits [3:0] of the len field = 1. `ready_and_o` is high during flit 1.
- **8-byte write:** `size_i`=3, `data_i`=all ones → 3 flits, `len`=2. Data bits [63:0] are ones. Bits at index 64 and above in the final flit are 0.
- **Size extremes:** `size_i`=0 write → `len`=1. `size_i`=7 (clamped) and `size_i`=6 → `len`=9, with 10 flits and identical output.
- **Random backpressure:** random `ready_and_i` stalls on a 64-byte write → `flit_o` is unchanged while stalled. The reassembled packet equals the expected packet bit-exact.
- **Back-to-back:** two messages with `v_i` held high and `ready_and_i`=1 → second flit 0 appears in the cycle directly after the first packet's last flit, with no bubble.
- **Reset mid-packet:** `reset_i` asserted during flit 4 of 10 → `v_o`=0 next cycle and `ready_and_o`=1. The next message starts cleanly at flit 0.
